// File: rtl/msdap_mem_writer.sv
// rtl/msdap_mem_writer.sv - write sequencer loading rj, coefficient and circular input-sample memories for the MSDAP datapath
module msdap_mem_writer #(
  parameter int RJ_WORDS    = 16,
  parameter int COEFF_WORDS = 512,
  parameter int SLEEP_COUNT = 800
) (
  input  logic        Sclk,
  input  logic        Clear_n,
  input  logic        word_valid,
  input  logic [15:0] wordL,
  input  logic [15:0] wordR,
  input  logic        data_reset,
  output logic        rj_we,
  output logic [3:0]  rj_waddr,
  output logic        coeff_we,
  output logic [8:0]  coeff_waddr,
  output logic        in_we,
  output logic [7:0]  in_waddr,
  output logic [15:0] wdataL,
  output logic [15:0] wdataR,
  output logic        work_enable,
  output logic        sleep_flag,
  output logic        alu_clear
);

  typedef enum logic [2:0] {LOAD_RJ, LOAD_COEFF, WORK, SLEEP, FLUSH} state_t;

  localparam logic [9:0] RJ_LAST    = 10'(RJ_WORDS - 1);
  localparam logic [9:0] COEFF_LAST = 10'(COEFF_WORDS - 1);
  localparam logic [9:0] SLEEP_MAX  = 10'(SLEEP_COUNT);
  localparam logic [9:0] FLUSH_LAST = 10'd255;

  state_t      state, next_state;
  logic [9:0]  wcnt, wcnt_n;
  logic [9:0]  zcnt, zcnt_n;
  logic [7:0]  xptr, xptr_n;
  logic        pend;

  logic        rj_wr, coeff_wr, samp_wr, flush_wr;
  logic [7:0]  flush_addr;
  logic        is_zero;

  logic        rj_we_d, coeff_we_d, in_we_d, pend_d;
  logic        work_enable_d, sleep_flag_d, alu_clear_d;
  logic [3:0]  rj_waddr_d;
  logic [8:0]  coeff_waddr_d;
  logic [7:0]  in_waddr_d;
  logic [15:0] wdataL_d, wdataR_d;

  assign is_zero = (wordL == 16'd0) && (wordR == 16'd0);

  always_ff @(posedge Sclk or negedge Clear_n) begin
    if (!Clear_n) begin
      state       <= LOAD_RJ;
      wcnt        <= '0;
      zcnt        <= '0;
      xptr        <= '0;
      pend        <= 1'b0;
      rj_we       <= 1'b0;
      rj_waddr    <= '0;
      coeff_we    <= 1'b0;
      coeff_waddr <= '0;
      in_we       <= 1'b0;
      in_waddr    <= '0;
      wdataL      <= '0;
      wdataR      <= '0;
      work_enable <= 1'b0;
      sleep_flag  <= 1'b0;
      alu_clear   <= 1'b1;
    end else begin
      state       <= next_state;
      wcnt        <= wcnt_n;
      zcnt        <= zcnt_n;
      xptr        <= xptr_n;
      pend        <= pend_d;
      rj_we       <= rj_we_d;
      rj_waddr    <= rj_waddr_d;
      coeff_we    <= coeff_we_d;
      coeff_waddr <= coeff_waddr_d;
      in_we       <= in_we_d;
      in_waddr    <= in_waddr_d;
      wdataL      <= wdataL_d;
      wdataR      <= wdataR_d;
      work_enable <= work_enable_d;
      sleep_flag  <= sleep_flag_d;
      alu_clear   <= alu_clear_d;
    end
  end

  // wcnt doubles as the flush sweep address; it is idle (zero) in WORK/SLEEP
  always_comb begin
    next_state = state;
    wcnt_n     = wcnt;
    zcnt_n     = zcnt;
    xptr_n     = xptr;
    rj_wr      = 1'b0;
    coeff_wr   = 1'b0;
    samp_wr    = 1'b0;
    flush_wr   = 1'b0;
    flush_addr = '0;
    case (state)
      LOAD_RJ: begin
        if (word_valid) begin
          rj_wr = 1'b1;
          if (wcnt == RJ_LAST) begin
            wcnt_n     = '0;
            next_state = LOAD_COEFF;
          end else begin
            wcnt_n = wcnt + 10'd1;
          end
        end
      end
      LOAD_COEFF: begin
        if (word_valid) begin
          coeff_wr = 1'b1;
          if (wcnt == COEFF_LAST) begin
            wcnt_n     = '0;
            xptr_n     = '0;
            zcnt_n     = '0;
            next_state = WORK;
          end else begin
            wcnt_n = wcnt + 10'd1;
          end
        end
      end
      WORK, SLEEP: begin
        if (data_reset) begin
          next_state = FLUSH;
          flush_wr   = 1'b1;
          wcnt_n     = 10'd1;
        end else if (word_valid) begin
          // a saturated zero run means we are asleep even if SLEEP is not yet registered
          if (is_zero && (state == SLEEP || zcnt == SLEEP_MAX)) begin
            next_state = SLEEP;
          end else begin
            samp_wr    = 1'b1;
            xptr_n     = xptr + 8'd1;
            zcnt_n     = is_zero ? zcnt + 10'd1 : '0;
            next_state = WORK;
          end
        end else if (zcnt == SLEEP_MAX) begin
          next_state = SLEEP;
        end
      end
      FLUSH: begin
        flush_wr = 1'b1;
        if (data_reset) begin
          wcnt_n = 10'd1;
        end else begin
          flush_addr = wcnt[7:0];
          if (wcnt == FLUSH_LAST) begin
            wcnt_n     = '0;
            xptr_n     = '0;
            zcnt_n     = '0;
            next_state = WORK;
          end else begin
            wcnt_n = wcnt + 10'd1;
          end
        end
      end
      default: next_state = LOAD_RJ;
    endcase
  end

  always_comb begin
    rj_we_d       = rj_wr;
    rj_waddr_d    = rj_wr ? wcnt[3:0] : rj_waddr;
    coeff_we_d    = coeff_wr;
    coeff_waddr_d = coeff_wr ? wcnt[8:0] : coeff_waddr;
    in_we_d       = samp_wr | flush_wr;
    in_waddr_d    = samp_wr ? xptr : (flush_wr ? flush_addr : in_waddr);
    wdataL_d      = wdataL;
    wdataR_d      = wdataR;
    if (rj_wr || coeff_wr || samp_wr) begin
      wdataL_d = wordL;
      wdataR_d = wordR;
    end else if (flush_wr) begin
      wdataL_d = '0;
      wdataR_d = '0;
    end
    pend_d        = samp_wr;
    // a sample pulse due in the cycle FLUSH starts is dropped with the flushed history
    work_enable_d = pend && (next_state != FLUSH);
    sleep_flag_d  = (next_state == SLEEP);
    alu_clear_d   = flush_wr || (next_state == LOAD_RJ) || (next_state == LOAD_COEFF) ||
                    (next_state == FLUSH);
  end

endmodule

// File: tb/tb_msdap_mem_writer.sv
// tb/tb_msdap_mem_writer.sv - randomized self-checking bench for msdap_mem_writer against an event-list model
module tb_msdap_mem_writer;

  logic        Sclk = 1'b0;
  logic        Clear_n = 1'b0;
  logic        word_valid = 1'b0;
  logic [15:0] wordL = '0;
  logic [15:0] wordR = '0;
  logic        data_reset = 1'b0;
  logic        rj_we, coeff_we, in_we, work_enable, sleep_flag, alu_clear;
  logic [3:0]  rj_waddr;
  logic [8:0]  coeff_waddr;
  logic [7:0]  in_waddr;
  logic [15:0] wdataL, wdataR;

  msdap_mem_writer dut (
    .Sclk(Sclk), .Clear_n(Clear_n), .word_valid(word_valid), .wordL(wordL), .wordR(wordR),
    .data_reset(data_reset), .rj_we(rj_we), .rj_waddr(rj_waddr), .coeff_we(coeff_we),
    .coeff_waddr(coeff_waddr), .in_we(in_we), .in_waddr(in_waddr), .wdataL(wdataL),
    .wdataR(wdataR), .work_enable(work_enable), .sleep_flag(sleep_flag), .alu_clear(alu_clear)
  );

  always #5 Sclk = ~Sclk;

  // kind: 0 rj write, 1 coeff write, 2 input write, 3 work_enable pulse
  typedef struct packed {
    int          stamp;
    logic [1:0]  kind;
    logic [9:0]  addr;
    logic [15:0] l;
    logic [15:0] r;
    logic        alu;
    logic        slp;
  } ev_t;

  ev_t got_q[$];
  ev_t exp_q[$];
  int  cyc = 0;
  int  excl_viol = 0;
  int  n_tests = 0;
  int  n_fail = 0;
  int  m_rj, m_co, m_ptr, m_zrun, m_fl_until;

  function automatic ev_t mk(int st, int k, int a, logic [15:0] l, logic [15:0] r, logic alu, logic slp);
    ev_t e;
    e.stamp = st; e.kind = k[1:0]; e.addr = a[9:0]; e.l = l; e.r = r; e.alu = alu; e.slp = slp;
    return e;
  endfunction

  function automatic string ev_str(ev_t e);
    return $sformatf("st=%0d k=%0d a=%0d L=%h R=%h alu=%b slp=%b", e.stamp, e.kind, e.addr, e.l, e.r, e.alu, e.slp);
  endfunction

  always @(posedge Sclk) cyc <= cyc + 1;

  always @(negedge Sclk) begin
    if (work_enable) got_q.push_back(mk(cyc, 3, 0, 16'd0, 16'd0, alu_clear, sleep_flag));
    if (rj_we)    got_q.push_back(mk(cyc, 0, int'(rj_waddr), wdataL, wdataR, alu_clear, sleep_flag));
    if (coeff_we) got_q.push_back(mk(cyc, 1, int'(coeff_waddr), wdataL, wdataR, alu_clear, sleep_flag));
    if (in_we)    got_q.push_back(mk(cyc, 2, int'(in_waddr), wdataL, wdataR, alu_clear, sleep_flag));
    if (int'(rj_we) + int'(coeff_we) + int'(in_we) > 1) excl_viol++;
  end

  // Reference: loads fill 16 rj then 512 coeff slots; samples go round a 256-entry ring
  function automatic void model_reset();
    m_rj = 0; m_co = 0; m_ptr = 0; m_zrun = 0; m_fl_until = -1;
  endfunction

  function automatic void model_word(logic [15:0] l, logic [15:0] r, int st);
    if (m_rj < 16) begin
      exp_q.push_back(mk(st, 0, m_rj, l, r, 1'b1, 1'b0));
      m_rj++;
    end else if (m_co < 512) begin
      exp_q.push_back(mk(st, 1, m_co, l, r, (m_co == 511) ? 1'b0 : 1'b1, 1'b0));
      m_co++;
    end else if (st <= m_fl_until) begin
      // flush in progress: word ignored
    end else if (l == 16'd0 && r == 16'd0 && m_zrun == 800) begin
      // asleep: zero sample dropped
    end else begin
      m_zrun = (l == 16'd0 && r == 16'd0) ? m_zrun + 1 : 0;
      exp_q.push_back(mk(st, 2, m_ptr, l, r, 1'b0, 1'b0));
      exp_q.push_back(mk(st + 1, 3, 0, 16'd0, 16'd0, 1'b0, m_zrun == 800));
      m_ptr = (m_ptr + 1) % 256;
    end
  endfunction

  function automatic void model_flush(int st);
    while (exp_q.size() > 0 && exp_q[$].stamp >= st) void'(exp_q.pop_back());
    for (int k = 0; k < 256; k++) exp_q.push_back(mk(st + k, 2, k, 16'd0, 16'd0, 1'b1, 1'b0));
    m_ptr = 0; m_zrun = 0; m_fl_until = st + 255;
  endfunction

  task automatic drive(input logic [15:0] l, input logic [15:0] r, input logic vld, input logic dr);
    word_valid = vld; wordL = l; wordR = r; data_reset = dr;
    if (dr) model_flush(cyc + 1);
    else if (vld) model_word(l, r, cyc + 1);
    @(posedge Sclk); #1;
    word_valid = 1'b0; data_reset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Sclk);
    #1;
  endtask

  task automatic test_reset();
    idle(2);
    n_tests++;
    if ({rj_we, coeff_we, in_we, work_enable, sleep_flag, alu_clear} !== 6'b000001) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 000001", {rj_we, coeff_we, in_we, work_enable, sleep_flag, alu_clear});
    end
    n_tests++;
    if ({rj_waddr, coeff_waddr, in_waddr} !== 21'd0) begin
      n_fail++; $display("FAIL reset_addr got %h want 0", {rj_waddr, coeff_waddr, in_waddr});
    end
    n_tests++;
    if ({wdataL, wdataR} !== 32'd0) begin
      n_fail++; $display("FAIL reset_data got %h want 0", {wdataL, wdataR});
    end
    Clear_n = 1'b1;
    model_reset();
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_load();
    for (int i = 0; i < 16; i++) drive(16'(i + 1), 16'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 512; i++) begin
      drive(16'($urandom), 16'($urandom), 1'b1, 1'b0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(3);
    n_tests++;
    if ({alu_clear, sleep_flag} !== 2'b00) begin
      n_fail++; $display("FAIL load_alu_clear got %b want 00", {alu_clear, sleep_flag});
    end
    n_tests++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL load_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL load_ev[%0d] got %s want %s", i, ev_str(got_q[i]), ev_str(exp_q[i])); break;
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_circular();
    for (int i = 0; i < 300; i++) drive(16'($urandom_range(1, 65535)), 16'($urandom), 1'b1, 1'b0);
    idle(3);
    n_tests++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL circ_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL circ_ev[%0d] got %s want %s", i, ev_str(got_q[i]), ev_str(exp_q[i])); break;
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_sleep();
    for (int i = 0; i < 800; i++) drive(16'd0, 16'd0, 1'b1, 1'b0);
    idle(3);
    n_tests++;
    if (sleep_flag !== 1'b1) begin
      n_fail++; $display("FAIL sleep_enter got %b want 1", sleep_flag);
    end
    for (int i = 0; i < 5; i++) drive(16'd0, 16'd0, 1'b1, 1'b0);
    idle(2);
    n_tests++;
    if (sleep_flag !== 1'b1) begin
      n_fail++; $display("FAIL sleep_hold got %b want 1", sleep_flag);
    end
    drive(16'h0003, 16'd0, 1'b1, 1'b0);
    n_tests++;
    if ({in_we, sleep_flag} !== 2'b10) begin
      n_fail++; $display("FAIL sleep_wake got we/slp=%b want 10", {in_we, sleep_flag});
    end
    idle(3);
    n_tests++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL sleep_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL sleep_ev[%0d] got %s want %s", i, ev_str(got_q[i]), ev_str(exp_q[i])); break;
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_zero_interrupt();
    for (int i = 0; i < 799; i++) drive(16'd0, 16'd0, 1'b1, 1'b0);
    drive(16'd0, 16'($urandom_range(1, 65535)), 1'b1, 1'b0);
    for (int i = 0; i < 799; i++) drive(16'd0, 16'd0, 1'b1, 1'b0);
    idle(3);
    n_tests++;
    if (sleep_flag !== 1'b0) begin
      n_fail++; $display("FAIL zrun_sleep got %b want 0", sleep_flag);
    end
    n_tests++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL zrun_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL zrun_ev[%0d] got %s want %s", i, ev_str(got_q[i]), ev_str(exp_q[i])); break;
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_flush();
    while (m_ptr != 128) drive(16'($urandom_range(1, 65535)), 16'($urandom), 1'b1, 1'b0);
    drive(16'h5a5a, 16'ha5a5, 1'b1, 1'b1);
    n_tests++;
    if ({in_we, in_waddr, alu_clear, work_enable} !== {1'b1, 8'd0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL flush_start got we=%b a=%0d alu=%b wen=%b want we=1 a=0 alu=1 wen=0",
                         in_we, in_waddr, alu_clear, work_enable);
    end
    idle(100);
    drive(16'h1234, 16'h4321, 1'b1, 1'b0);
    idle(20);
    drive(16'd0, 16'd0, 1'b0, 1'b1);
    idle(262);
    drive(16'h00ab, 16'h00cd, 1'b1, 1'b0);
    idle(3);
    n_tests++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL flush_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL flush_ev[%0d] got %s want %s", i, ev_str(got_q[i]), ev_str(exp_q[i])); break;
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_midload_reset();
    Clear_n = 1'b0;
    idle(1);
    Clear_n = 1'b1;
    model_reset();
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 216; i++) drive(16'($urandom), 16'($urandom), 1'b1, 1'b0);
    idle(2);
    #2 Clear_n = 1'b0;
    #1;
    n_tests++;
    if ({rj_we, coeff_we, in_we, work_enable, sleep_flag, alu_clear} !== 6'b000001) begin
      n_fail++; $display("FAIL midrst_ctrl got %b want 000001", {rj_we, coeff_we, in_we, work_enable, sleep_flag, alu_clear});
    end
    n_tests++;
    if ({rj_waddr, coeff_waddr, in_waddr, wdataL, wdataR} !== 53'd0) begin
      n_fail++; $display("FAIL midrst_addr_data got %h want 0", {rj_waddr, coeff_waddr, in_waddr, wdataL, wdataR});
    end
    model_reset();
    @(posedge Sclk); #1;
    Clear_n = 1'b1;
    for (int i = 0; i < 528; i++) drive(16'($urandom), 16'($urandom), 1'b1, 1'b0);
    idle(3);
    n_tests++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL midrst_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL midrst_ev[%0d] got %s want %s", i, ev_str(got_q[i]), ev_str(exp_q[i])); break;
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [15:0] l, r;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) begin l = 16'd0; r = 16'd0; end
      else begin l = 16'($urandom); r = 16'($urandom); end
      drive(l, r, 1'b1, ($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(270);
    n_tests++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL b2b_ev[%0d] got %s want %s", i, ev_str(got_q[i]), ev_str(exp_q[i])); break;
      end
    end
    n_tests++;
    if (excl_viol !== 0) begin
      n_fail++; $display("FAIL we_exclusive got %0d overlaps want 0", excl_viol);
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_circular();
    test_sleep();
    test_zero_interrupt();
    test_flush();
    test_midload_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
